// File: rtl/serial_adder_n.sv
// serial_adder_n: multi-cycle adder/subtractor consuming STEP bits per clock, LSB chunk first
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_next;
  logic [CW-1:0]    cnt;
  logic [STEP-1:0]  r;
  logic             cy, co, cm, last, accept;
  assign {co, r} = {1'b0, a_sr[STEP-1:0]} + {1'b0, b_sr[STEP-1:0]} + (STEP+1)'(cy);
  assign cm      = a_sr[STEP-1] ^ b_sr[STEP-1] ^ r[STEP-1];
  assign s_next  = WIDTH'({r, s_sr} >> STEP);
  assign last    = state == RUN && cnt == CW'(N - 1);
  assign accept  = start && state != RUN;
  assign busy    = state == RUN;
  assign done    = state == FIN;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: RUN lasts N edges, FIN one cycle unless restarted
  always_comb begin
    state_n = state;
    state_n = state == RUN ? (last ? FIN : RUN) : (start ? RUN : IDLE);
  end
  // operand shifters, chunk carry and registered results
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sr <= A;
      b_sr <= sub ? ~B : B;
      cy   <= sub | Cin;
      cnt  <= '0;
      s_sr <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> STEP;
      b_sr <= b_sr >> STEP;
      s_sr <= s_next;
      cy   <= co;
      cnt  <= cnt + 1'b1;
      if (last) begin
        sum   <= s_next;
        carry <= co;
        ovf   <= cm ^ co;
      end
    end
endmodule

// File: tb/tb_serial_adder_n.sv
// tb_serial_adder_n: directed and exhaustive checks of serial_adder_n in three configurations
module tb_serial_adder_n;
  logic       clk = 1'b0, rst = 1'b1, sub = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       st1 = 1'b0, st2 = 1'b0, st3 = 1'b0;
  logic       bz1, dn1, cy1, ov1, bz2, dn2, cy2, ov2, bz3, dn3, cy3, ov3;
  logic [7:0] sm1, sm2;
  logic [3:0] sm3;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(8), .STEP(1)) u1 (.clk(clk), .rst(rst), .start(st1), .sub(sub), .A(a), .B(b),
    .Cin(cin), .busy(bz1), .done(dn1), .sum(sm1), .carry(cy1), .ovf(ov1));
  serial_adder_n #(.WIDTH(8), .STEP(4)) u2 (.clk(clk), .rst(rst), .start(st2), .sub(sub), .A(a), .B(b),
    .Cin(cin), .busy(bz2), .done(dn2), .sum(sm2), .carry(cy2), .ovf(ov2));
  serial_adder_n #(.WIDTH(4), .STEP(2)) u3 (.clk(clk), .rst(rst), .start(st3), .sub(sub), .A(a[3:0]),
    .B(b[3:0]), .Cin(cin), .busy(bz3), .done(dn3), .sum(sm3), .carry(cy3), .ovf(ov3));

  typedef struct {
    int         d;
    logic       sb, ci;
    logic [7:0] x, y, s;
    logic       c, v;
    int         n;
  } vec_t;

  // {busy, done, carry, ovf, sum[7:0]}
  function automatic logic [11:0] o(input int d);
    return d == 1 ? {bz1, dn1, cy1, ov1, sm1} : d == 2 ? {bz2, dn2, cy2, ov2, sm2} : {bz3, dn3, cy3, ov3, 4'h0, sm3};
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h exp=%h", nm, i, act, exp);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    st1 = d == 1 ? v : st1;
    st2 = d == 2 ? v : st2;
    st3 = d == 3 ? v : st3;
  endtask

  task automatic wait_done(input int d, output int lat, output logic [11:0] r);
    lat = 0;
    r = o(d);
    while (!r[10] && lat < 40) begin
      @(negedge clk);
      lat++;
      r = o(d);
    end
  endtask

  task automatic run_op(input int d, input logic sb, input logic ci, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output logic bz, output logic [11:0] r);
    @(negedge clk);
    sub = sb; cin = ci; a = x; b = y;
    set_start(d, 1'b1);
    @(negedge clk);
    set_start(d, 1'b0);
    r = o(d);
    bz = r[11];
    wait_done(d, lat, r);
  endtask

  initial begin
    vec_t        tv[9];
    int          lat, nd;
    logic        bz;
    logic [11:0] r;
    logic [3:0]  yy;
    logic [4:0]  f;
    logic [3:0]  m;
    tv[0] = '{1, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 8};
    tv[1] = '{1, 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 8};
    tv[2] = '{1, 1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 8};
    tv[3] = '{1, 1'b1, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 8};
    tv[4] = '{1, 1'b1, 1'b0, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 8};
    tv[5] = '{1, 1'b0, 1'b1, 8'h12, 8'h34, 8'h47, 1'b0, 1'b0, 8};
    tv[6] = '{2, 1'b0, 1'b1, 8'hA5, 8'h5A, 8'h00, 1'b1, 1'b0, 2};
    tv[7] = '{2, 1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 2};
    tv[8] = '{2, 1'b1, 1'b0, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 2};
    #2;
    chk("reset1", 0, 32'(o(1)), 0);
    chk("reset3", 0, 32'(o(3)), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_op(tv[i].d, tv[i].sb, tv[i].ci, tv[i].x, tv[i].y, lat, bz, r);
      chk("lat", i, lat, tv[i].n);
      chk("busy", i, 32'(bz), 1);
      chk("sum", i, 32'(r[7:0]), 32'(tv[i].s));
      chk("carry", i, 32'(r[9]), 32'(tv[i].c));
      chk("ovf", i, 32'(r[8]), 32'(tv[i].v));
    end
    // restart while running is ignored
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; a = 8'h11; b = 8'h22; st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    wait_done(1, lat, r);
    chk("ign_lat", 0, lat, 6);
    chk("ign_sum", 0, 32'(r[9:0]), 32'h033);
    @(negedge clk);
    chk("ign_idle", 0, 32'({bz1, dn1}), 0);
    // start held high through FIN restarts with no gap
    @(negedge clk);
    cin = 1'b0; a = 8'h01; b = 8'h02; st1 = 1'b1;
    @(negedge clk);
    wait_done(1, lat, r);
    chk("b2b_sum1", 0, 32'(r[9:0]), 32'h003);
    a = 8'h04; b = 8'h05;
    @(negedge clk);
    chk("b2b_busy", 0, 32'({bz1, dn1}), 32'b10);
    st1 = 1'b0;
    wait_done(1, lat, r);
    chk("b2b_lat", 0, lat, 8);
    chk("b2b_sum2", 0, 32'(r[9:0]), 32'h009);
    // asynchronous reset in the middle of a run
    @(negedge clk);
    a = 8'h7F; b = 8'h01; st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 0, 32'(bz1), 1);
    rst = 1'b1;
    #1;
    chk("rst_out", 0, 32'(o(1)), 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      nd += int'(dn1) + int'(bz1);
    end
    chk("rst_quiet", 0, nd, 0);
    run_op(1, 1'b0, 1'b0, 8'h7F, 8'h01, lat, bz, r);
    chk("rst_after", 0, {lat[7:0], 14'h0, r[9:0]}, {8'd8, 14'h0, 10'h180});
    // exhaustive 4-bit, two bits per clock
    for (int k = 0; k < 1024; k++) begin
      logic [3:0] x4, y4;
      logic       sb, ci;
      x4 = 4'(k);
      y4 = 4'(k >> 4);
      ci = k[8];
      sb = k[9];
      yy = sb ? ~y4 : y4;
      f = {1'b0, x4} + {1'b0, yy} + 5'(sb | ci);
      m = {1'b0, x4[2:0]} + {1'b0, yy[2:0]} + 4'(sb | ci);
      run_op(3, sb, ci, {4'h0, x4}, {4'h0, y4}, lat, bz, r);
      chk("exh", k, {lat[7:0], 18'h0, r[3:0], r[9], r[8]}, {8'd2, 18'h0, f[3:0], f[4], m[3] ^ f[4]});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
